// File: rtl/tx_arbiter.sv
// tx_arbiter: arbitrates three byte requesters onto one SPI transmitter with
// exactly one byte in flight and a stall watchdog on the granted requester.
module tx_arbiter #(
   parameter int         RR      = 1,
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        clock,
   input  logic        extReset_n,
   input  logic [2:0]  req_valid,
   input  logic [7:0]  req_data0,
   input  logic [7:0]  req_data1,
   input  logic [7:0]  req_data2,
   input  logic [2:0]  req_last,
   output logic [2:0]  req_ready,
   output logic        tx_write,
   output logic [7:0]  tx_data,
   input  logic        tx_idle,
   output logic [2:0]  grant,
   output logic        busy,
   output logic        err_timeout,
   output logic [15:0] tx_byte_count
);

   // state | meaning
   // IDLE  | no owner; arbitrate when the transmitter is idle and anyone requests
   // SEND  | owner granted; accept its next byte once the transmitter is idle
   // GAP   | byte just written; give tx_idle one cycle to fall
   // POLL  | wait for the transmitter, then next byte or release the grant
   typedef enum logic [1:0] {IDLE, SEND, GAP, POLL} state_t;

   state_t     state;
   logic [7:0] wdog;
   logic [1:0] last_served;
   logic       last_flag;
   logic [1:0] gidx;
   logic [1:0] pick;
   logic       gvalid;
   logic       glast;
   logic [7:0] gdata;

   always_comb begin
      gidx = 2'd0;
      if (grant[1])
         gidx = 2'd1;
      else if (grant[2])
         gidx = 2'd2;
   end

   always_comb begin
      gvalid = 1'b0;
      glast  = 1'b0;
      gdata  = 8'h00;
      case (gidx)
         2'd0: begin
            gvalid = req_valid[0];
            glast  = req_last[0];
            gdata  = req_data0;
         end
         2'd1: begin
            gvalid = req_valid[1];
            glast  = req_last[1];
            gdata  = req_data1;
         end
         2'd2: begin
            gvalid = req_valid[2];
            glast  = req_last[2];
            gdata  = req_data2;
         end
         default: begin
            gvalid = 1'b0;
            glast  = 1'b0;
            gdata  = 8'h00;
         end
      endcase
   end

   // Winner is only consumed when at least one request is valid.
   always_comb begin
      pick = 2'd0;
      if (RR != 0) begin
         case (last_served)
            2'd0:    pick = req_valid[1] ? 2'd1 : (req_valid[2] ? 2'd2 : 2'd0);
            2'd1:    pick = req_valid[2] ? 2'd2 : (req_valid[0] ? 2'd0 : 2'd1);
            default: pick = req_valid[0] ? 2'd0 : (req_valid[1] ? 2'd1 : 2'd2);
         endcase
      end else begin
         pick = req_valid[0] ? 2'd0 : (req_valid[1] ? 2'd1 : 2'd2);
      end
   end

   assign busy      = (state != IDLE);
   assign req_ready = (extReset_n && state == SEND && tx_idle) ? grant : 3'b000;

   always_ff @(posedge clock) begin
      if (!extReset_n) begin
         state         <= IDLE;
         grant         <= 3'b000;
         tx_write      <= 1'b0;
         tx_data       <= 8'h00;
         err_timeout   <= 1'b0;
         tx_byte_count <= 16'h0000;
         wdog          <= 8'h00;
         last_served   <= 2'd2;
         last_flag     <= 1'b0;
      end else begin
         tx_write    <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_idle && req_valid != 3'b000) begin
                  grant <= 3'b001 << pick;
                  wdog  <= 8'h00;
                  state <= SEND;
               end
            end
            SEND: begin
               if (gvalid && tx_idle) begin
                  tx_write      <= 1'b1;
                  tx_data       <= gdata;
                  tx_byte_count <= tx_byte_count + 16'd1;
                  last_flag     <= glast;
                  wdog          <= 8'h00;
                  state         <= GAP;
               end else if (!gvalid) begin
                  // Revoke on the cycle the count would reach TIMEOUT.
                  if (wdog == TIMEOUT - 8'd1) begin
                     err_timeout <= 1'b1;
                     grant       <= 3'b000;
                     last_served <= gidx;
                     wdog        <= 8'h00;
                     state       <= IDLE;
                  end else begin
                     wdog <= wdog + 8'd1;
                  end
               end
            end
            GAP: state <= POLL;
            POLL: begin
               if (tx_idle) begin
                  if (last_flag) begin
                     grant       <= 3'b000;
                     last_served <= gidx;
                     state       <= IDLE;
                  end else begin
                     wdog  <= 8'h00;
                     state <= SEND;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
